// File: rtl/tournament_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tournament_grant_ctrl
// Purpose  : Grant stage behind the base-4 tournament selector. Captures the
//            winning entry, offers a one-hot grant to the winning requester,
//            holds it until the requester releases it, and masks the holder's
//            entry upstream so the tournament can pick the next winner.
// Ports    : clock      - system clock, rising edge
//            reset      - asynchronous active-low reset
//            I_Entry    - winning entry (bit WIDTH_UNITS is the valid bit)
//            I_Valid    - tournament any-input-valid flag
//            I_Win      - tournament one-hot win flags {V3,V2,V1,V0}
//            I_Stall    - downstream back-pressure, blocks new captures
//            I_Ack      - per-requester grant acceptance
//            I_Done     - per-requester release of a held grant
//            O_Grant    - one-hot grant offer/hold
//            O_Entry    - registered winning entry
//            O_Mask     - one-hot mask forcing the holder's entry invalid
//            O_Busy     - high whenever the controller is not idle
//            O_Timeout  - one-cycle pulse when an offer expires
// Revision : 1.0 - initial release
// ============================================================================
module tournament_grant_ctrl #(
    parameter int WIDTH_UNITS    = 8,
    parameter int WIDTH_TIMER    = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH_UNITS:0]   I_Entry,
    input  logic                   I_Valid,
    input  logic [3:0]             I_Win,
    input  logic                   I_Stall,
    input  logic [3:0]             I_Ack,
    input  logic [3:0]             I_Done,
    output logic [3:0]             O_Grant,
    output logic [WIDTH_UNITS:0]   O_Entry,
    output logic [3:0]             O_Mask,
    output logic                   O_Busy,
    output logic                   O_Timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OFFER   = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Last timer value of an offer: the offer lasts TIMEOUT_CYCLES cycles.
    localparam logic [WIDTH_TIMER-1:0] c_timer_last = WIDTH_TIMER'(TIMEOUT_CYCLES - 1);

    state_t                  r_state;
    logic [WIDTH_TIMER-1:0]  r_timer;
    logic [3:0]              r_idx;      // captured winner, kept one-hot

    logic                    w_win_onehot;
    logic                    w_capture;
    logic                    w_ack;
    logic                    w_done;

    // The tournament still flags a winner when every entry is invalid, so the
    // entry's own valid bit and a strictly one-hot win vector are both needed.
    assign w_win_onehot = (I_Win != 4'd0) && ((I_Win & (I_Win - 4'd1)) == 4'd0);
    assign w_capture    = I_Valid & I_Entry[WIDTH_UNITS] & ~I_Stall & w_win_onehot;

    // Only the captured requester's ack/done bits matter.
    assign w_ack  = |(I_Ack  & r_idx);
    assign w_done = |(I_Done & r_idx);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_idx     <= '0;
            O_Grant   <= '0;
            O_Entry   <= '0;
            O_Mask    <= '0;
            O_Busy    <= 1'b0;
            O_Timeout <= 1'b0;
        end else begin
            O_Timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_state <= S_OFFER;
                        r_idx   <= I_Win;
                        O_Entry <= I_Entry;
                        O_Grant <= I_Win;
                        r_timer <= '0;
                        O_Busy  <= 1'b1;
                    end
                end
                S_OFFER: begin
                    // Ack takes priority over an expiry in the same cycle.
                    if (w_ack) begin
                        r_state <= S_HOLD;
                        O_Mask  <= r_idx;
                    end else if (r_timer == c_timer_last) begin
                        r_state   <= S_IDLE;
                        O_Grant   <= '0;
                        O_Entry   <= '0;
                        O_Busy    <= 1'b0;
                        O_Timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_done) begin
                        r_state <= S_RELEASE;
                        O_Grant <= '0;
                        O_Mask  <= '0;
                        O_Entry <= '0;
                    end
                end
                S_RELEASE: begin
                    // No capture here: the tournament needs one cycle to
                    // re-evaluate with the mask removed.
                    r_state <= S_IDLE;
                    O_Busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    O_Grant <= '0;
                    O_Mask  <= '0;
                    O_Entry <= '0;
                    O_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tournament_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tournament_grant_ctrl
// Purpose  : Self-checking bench for tournament_grant_ctrl. Directed scenarios
//            followed by randomized traffic, all compared each cycle against
//            a behavioural model of the grant protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tournament_grant_ctrl;

    localparam int WU = 8;
    localparam int WT = 8;
    localparam int TO = 16;

    localparam int P_IDLE    = 0;
    localparam int P_OFFER   = 1;
    localparam int P_HOLD    = 2;
    localparam int P_RELEASE = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [WU:0]   I_Entry;
    logic          I_Valid;
    logic [3:0]    I_Win;
    logic          I_Stall;
    logic [3:0]    I_Ack;
    logic [3:0]    I_Done;
    logic [3:0]    O_Grant;
    logic [WU:0]   O_Entry;
    logic [3:0]    O_Mask;
    logic          O_Busy;
    logic          O_Timeout;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: protocol phase, winner number, cycles spent offering.
    int            m_phase;
    int            m_who;
    int            m_age;
    logic [WU:0]   m_entry;
    logic          m_to;

    tournament_grant_ctrl #(
        .WIDTH_UNITS    (WU),
        .WIDTH_TIMER    (WT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .I_Entry   (I_Entry),
        .I_Valid   (I_Valid),
        .I_Win     (I_Win),
        .I_Stall   (I_Stall),
        .I_Ack     (I_Ack),
        .I_Done    (I_Done),
        .O_Grant   (O_Grant),
        .O_Entry   (O_Entry),
        .O_Mask    (O_Mask),
        .O_Busy    (O_Busy),
        .O_Timeout (O_Timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_grant;
        logic [3:0] e_mask;
        e_grant = (m_phase == P_OFFER || m_phase == P_HOLD) ? 4'(1 << m_who) : 4'd0;
        e_mask  = (m_phase == P_HOLD) ? 4'(1 << m_who) : 4'd0;
        check({tag, ".grant"},   32'(O_Grant),   32'(e_grant));
        check({tag, ".entry"},   32'(O_Entry),   32'(m_entry));
        check({tag, ".mask"},    32'(O_Mask),    32'(e_mask));
        check({tag, ".busy"},    32'(O_Busy),    32'(m_phase != P_IDLE));
        check({tag, ".timeout"}, 32'(O_Timeout), 32'(m_to));
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_who   = 0;
        m_age   = 0;
        m_entry = '0;
        m_to    = 1'b0;
    endtask

    // Advance the model by one clock edge using the current input values.
    task automatic model_step();
        bit qualified;
        qualified = I_Valid && I_Entry[WU] && !I_Stall && ($countones(I_Win) == 1);
        m_to = 1'b0;
        case (m_phase)
            P_IDLE: if (qualified) begin
                for (int i = 0; i < 4; i++) if (I_Win[i]) m_who = i;
                m_phase = P_OFFER;
                m_entry = I_Entry;
                m_age   = 0;
            end
            P_OFFER: begin
                if (I_Ack[m_who]) begin
                    m_phase = P_HOLD;
                end else begin
                    m_age++;
                    if (m_age == TO) begin
                        m_phase = P_IDLE;
                        m_entry = '0;
                        m_to    = 1'b1;
                    end
                end
            end
            P_HOLD: if (I_Done[m_who]) begin
                m_phase = P_RELEASE;
                m_entry = '0;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic quiet_inputs();
        I_Entry = '0;
        I_Valid = 1'b0;
        I_Win   = 4'd0;
        I_Stall = 1'b0;
        I_Ack   = 4'd0;
        I_Done  = 4'd0;
    endtask

    task automatic present(input logic [WU:0] entry, input logic [3:0] win);
        I_Entry = entry;
        I_Win   = win;
        I_Valid = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        quiet_inputs();
        model_reset();
        @(negedge clock);
        check_outputs("reset");
        reset = 1'b1;
        tick("idle0");

        // Basic grant to index 1.
        present(9'h10A, 4'b0010);
        tick("basic.cap");
        quiet_inputs();
        tick("basic.offer");
        I_Ack = 4'b0010;
        tick("basic.ack");
        I_Ack = 4'b0000;
        tick("basic.hold");
        I_Done = 4'b0010;
        tick("basic.release");
        I_Done = 4'b0000;
        tick("basic.idle");

        // All invalid, tournament still flags Valid3.
        I_Entry = '0;
        I_Valid = 1'b0;
        I_Win   = 4'b1000;
        for (int i = 0; i < 20; i++) tick("allinv");
        // Valid entry but zero / multi-hot win flags: no capture.
        present(9'h155, 4'b0000);
        tick("win0");
        present(9'h155, 4'b0110);
        tick("multihot");
        present(9'h055, 4'b0100);
        tick("entry_invalid");

        // Timeout with no ack.
        present(9'h1C3, 4'b0100);
        tick("to.cap");
        quiet_inputs();
        for (int i = 0; i < 18; i++) tick("to.run");

        // Ack on the last offer cycle wins over the timeout.
        present(9'h1C3, 4'b0100);
        tick("toack.cap");
        quiet_inputs();
        for (int i = 0; i < 15; i++) tick("toack.run");
        I_Ack = 4'b0100;
        tick("toack.ack");
        I_Ack = 4'b0000;
        for (int i = 0; i < 3; i++) tick("toack.hold");
        I_Done = 4'b0100;
        tick("toack.rel");
        I_Done = 4'b0000;
        tick("toack.idle");

        // Wrong-index ack/done and done during offer are ignored.
        present(9'h1FF, 4'b0001);
        tick("wrong.cap");
        present(9'h1AA, 4'b1000);
        I_Ack  = 4'b1110;
        tick("wrong.ack");
        I_Ack  = 4'b0000;
        I_Done = 4'b0001;
        tick("wrong.done_in_offer");
        I_Done = 4'b0000;
        I_Ack  = 4'b0001;
        tick("wrong.good_ack");
        I_Ack  = 4'b0000;
        I_Done = 4'b1110;
        tick("wrong.done");
        I_Done = 4'b0001;
        I_Stall = 1'b1;
        tick("wrong.rel");
        I_Done = 4'b0000;

        // Stall blocks captures in idle only.
        present(9'h1AA, 4'b1000);
        for (int i = 0; i < 3; i++) tick("stall");
        I_Stall = 1'b0;
        tick("stall.cap");
        I_Stall = 1'b1;
        I_Ack   = 4'b1000;
        tick("stall.ack");
        I_Ack   = 4'b0000;
        tick("stall.hold");

        // Back-to-back: index 3 released while index 1 already wins.
        I_Stall = 1'b0;
        present(9'h10A, 4'b0010);
        I_Done = 4'b1000;
        tick("b2b.release");
        I_Done = 4'b0000;
        tick("b2b.idle");
        tick("b2b.cap");
        I_Ack = 4'b0010;
        tick("b2b.ack");
        quiet_inputs();
        tick("b2b.hold");

        // Asynchronous reset while holding.
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("rst.async");
        @(negedge clock);
        reset = 1'b1;
        present(9'h133, 4'b0001);
        tick("rst.recap");
        quiet_inputs();
        tick("rst.offer");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            I_Valid = ($urandom_range(0, 7) != 0);
            I_Entry = {1'($urandom_range(0, 3) != 0), 8'($urandom)};
            if ($urandom_range(0, 3) != 0) I_Win = 4'(1 << $urandom_range(0, 3));
            else                           I_Win = 4'($urandom);
            I_Stall = ($urandom_range(0, 4) == 0);
            I_Ack   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            I_Done  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
